// File: rtl/fetch_unit_v2.sv
// Instruction-fetch stage: owns the PC, drives an async-read instruction memory and
// registers decoded fields into IF/ID. Supports stall, redirect flush, LDM capture and one interrupt level.
module fetch_unit_v2 #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] PC_STEP      = ADDR_W'(1),
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(32'h20),
  parameter logic [ADDR_W-1:0] INT_VECTOR   = ADDR_W'(32'h0),
  parameter logic [4:0]        NOP_OPCODE   = 5'b00000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              ret_taken,
  input  logic [ADDR_W-1:0] ret_pc,
  input  logic              interrupt,
  input  logic              ldm_signal,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  output logic              ifid_valid,
  output logic [ADDR_W-1:0] ifid_pc_next,
  output logic [4:0]        ifid_opcode,
  output logic [2:0]        ifid_rs,
  output logic [2:0]        ifid_rd,
  output logic [4:0]        ifid_shamt,
  output logic [15:0]       ifid_imm,
  output logic              ifid_imm_valid,
  output logic              int_ack,
  output logic [ADDR_W-1:0] int_ret_pc
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] pc_next;
    logic [4:0]        opcode;
    logic [2:0]        rs;
    logic [2:0]        rd;
    logic [4:0]        shamt;
  } ifid_t;

  typedef enum logic [2:0] {ACT_SEQ, ACT_STALL, ACT_RET, ACT_BR, ACT_LDM, ACT_INT} act_e;

  localparam ifid_t IFID_BUBBLE = '{valid: 1'b0, pc_next: '0, opcode: NOP_OPCODE,
                                    rs: '0, rd: '0, shamt: '0};

  logic [ADDR_W-1:0] r_pc;
  ifid_t             r_ifid;
  logic [15:0]       r_imm;
  logic              r_imm_valid;
  logic              r_int_ack;
  logic [ADDR_W-1:0] r_int_ret_pc;
  logic              r_int_pending;
  logic              r_in_isr;

  act_e              w_act;
  logic              w_pend;
  logic [ADDR_W-1:0] w_pc_inc;
  ifid_t             w_fetched;

  // A request arriving on the entry edge itself is used immediately (latch-and-use).
  assign w_pend   = r_int_pending | interrupt;
  assign w_pc_inc = r_pc + PC_STEP;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_act = ACT_SEQ;
    if (ret_taken)                  w_act = ACT_RET;
    else if (branch_taken)          w_act = ACT_BR;
    else if (!enable)               w_act = ACT_STALL;
    else if (ldm_signal)            w_act = ACT_LDM;
    else if (w_pend && !r_in_isr)   w_act = ACT_INT;
  end

  always_comb begin
    w_fetched = '{valid: 1'b1, pc_next: w_pc_inc, opcode: imem_rdata[15:11],
                  rs: imem_rdata[10:8], rd: imem_rdata[7:5], shamt: imem_rdata[4:0]};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_VECTOR;
      r_ifid        <= IFID_BUBBLE;
      r_imm         <= '0;
      r_imm_valid   <= 1'b0;
      r_int_ack     <= 1'b0;
      r_int_ret_pc  <= '0;
      r_int_pending <= 1'b0;
      r_in_isr      <= 1'b0;
    end else begin
      r_int_ack     <= 1'b0;
      r_int_pending <= w_pend;
      unique case (w_act)
        ACT_RET: begin
          r_pc        <= ret_pc;
          r_ifid      <= IFID_BUBBLE;
          r_imm_valid <= 1'b0;
          r_in_isr    <= 1'b0;
        end
        ACT_BR: begin
          r_pc        <= branch_target;
          r_ifid      <= IFID_BUBBLE;
          r_imm_valid <= 1'b0;
        end
        ACT_LDM: begin
          r_pc        <= w_pc_inc;
          r_ifid      <= IFID_BUBBLE;
          r_imm       <= imem_rdata;
          r_imm_valid <= 1'b1;
        end
        ACT_INT: begin
          // The word fetched at r_pc is dropped and re-fetched after the ISR returns.
          r_int_ret_pc  <= r_pc;
          r_pc          <= INT_VECTOR;
          r_ifid        <= IFID_BUBBLE;
          r_imm_valid   <= 1'b0;
          r_int_ack     <= 1'b1;
          r_int_pending <= 1'b0;
          r_in_isr      <= 1'b1;
        end
        ACT_STALL: begin
        end
        default: begin
          r_pc        <= w_pc_inc;
          r_ifid      <= w_fetched;
          r_imm_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr      = r_pc;
  assign ifid_valid     = r_ifid.valid;
  assign ifid_pc_next   = r_ifid.pc_next;
  assign ifid_opcode    = r_ifid.opcode;
  assign ifid_rs        = r_ifid.rs;
  assign ifid_rd        = r_ifid.rd;
  assign ifid_shamt     = r_ifid.shamt;
  assign ifid_imm       = r_imm;
  assign ifid_imm_valid = r_imm_valid;
  assign int_ack        = r_int_ack;
  assign int_ret_pc     = r_int_ret_pc;

endmodule

// File: tb/tb_fetch_unit_v2.sv
// Scoreboard bench for fetch_unit_v2: each step pushes its expected post-edge state,
// which is popped and compared one time unit after the clock edge.
module tb_fetch_unit_v2;

  localparam logic [4:0] CF  = 5'b00001; // opcode, rs, rd, shamt, pc_next
  localparam logic [4:0] CO  = 5'b00010; // opcode only
  localparam logic [4:0] CIV = 5'b00100; // imm_valid
  localparam logic [4:0] CI  = 5'b01000; // imm
  localparam logic [4:0] CR  = 5'b10000; // int_ret_pc

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic        ack;
    logic [4:0]  chk;
    logic [31:0] pc_next;
    logic [15:0] word;
    logic        imm_valid;
    logic [15:0] imm;
    logic [31:0] ret_pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        ret_taken = 1'b0;
  logic [31:0] ret_pc = '0;
  logic        interrupt = 1'b0;
  logic        ldm_signal = 1'b0;
  logic [31:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_pc_next;
  logic [4:0]  ifid_opcode;
  logic [2:0]  ifid_rs;
  logic [2:0]  ifid_rd;
  logic [4:0]  ifid_shamt;
  logic [15:0] ifid_imm;
  logic        ifid_imm_valid;
  logic        int_ack;
  logic [31:0] int_ret_pc;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_step  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_f(input logic [31:0] a);
    case (a)
      32'd32:  return 16'h0861;
      32'd33:  return 16'h1122;
      32'd34:  return 16'h2233;
      32'd40:  return 16'hBEEF;
      default: return {a[7:0], ~a[7:0]};
    endcase
  endfunction

  assign imem_rdata = mem_f(imem_addr);

  fetch_unit_v2 dut (
    .clk(clk), .reset(reset), .enable(enable),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .ret_taken(ret_taken), .ret_pc(ret_pc),
    .interrupt(interrupt), .ldm_signal(ldm_signal),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ifid_valid(ifid_valid), .ifid_pc_next(ifid_pc_next),
    .ifid_opcode(ifid_opcode), .ifid_rs(ifid_rs), .ifid_rd(ifid_rd), .ifid_shamt(ifid_shamt),
    .ifid_imm(ifid_imm), .ifid_imm_valid(ifid_imm_valid),
    .int_ack(int_ack), .int_ret_pc(int_ret_pc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic valid, input logic ack,
                              input logic [4:0] chk, input logic [31:0] pc_next,
                              input logic [15:0] word, input logic imm_valid,
                              input logic [15:0] imm, input logic [31:0] rpc);
    exp_t e;
    e = '{pc: pc, valid: valid, ack: ack, chk: chk, pc_next: pc_next, word: word,
          imm_valid: imm_valid, imm: imm, ret_pc: rpc};
    return e;
  endfunction

  task automatic compare(input int n, input exp_t e);
    check($sformatf("s%0d pc", n), imem_addr, e.pc);
    check($sformatf("s%0d valid", n), 32'(ifid_valid), 32'(e.valid));
    check($sformatf("s%0d int_ack", n), 32'(int_ack), 32'(e.ack));
    if ((e.chk & (CF | CO)) != 0)
      check($sformatf("s%0d opcode", n), 32'(ifid_opcode), 32'(e.word[15:11]));
    if ((e.chk & CF) != 0) begin
      check($sformatf("s%0d rs", n), 32'(ifid_rs), 32'(e.word[10:8]));
      check($sformatf("s%0d rd", n), 32'(ifid_rd), 32'(e.word[7:5]));
      check($sformatf("s%0d shamt", n), 32'(ifid_shamt), 32'(e.word[4:0]));
      check($sformatf("s%0d pc_next", n), ifid_pc_next, e.pc_next);
    end
    if ((e.chk & CIV) != 0)
      check($sformatf("s%0d imm_valid", n), 32'(ifid_imm_valid), 32'(e.imm_valid));
    if ((e.chk & CI) != 0)
      check($sformatf("s%0d imm", n), 32'(ifid_imm), 32'(e.imm));
    if ((e.chk & CR) != 0)
      check($sformatf("s%0d int_ret_pc", n), int_ret_pc, e.ret_pc);
  endtask

  task automatic step(input logic rst, input logic en, input logic br, input logic [31:0] bt,
                      input logic rt, input logic [31:0] rp, input logic intr, input logic ldm,
                      input exp_t e);
    @(negedge clk);
    reset = rst; enable = en; branch_taken = br; branch_target = bt;
    ret_taken = rt; ret_pc = rp; interrupt = intr; ldm_signal = ldm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    n_step++;
    compare(n_step, sb.pop_front());
  endtask

  task automatic seq(input exp_t e);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, e);
  endtask

  initial begin
    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0, mk(32, 0, 0, CF|CIV|CI|CR, 0, 16'h0000, 0, 0, 0));
    // Sequential fetch from the reset vector
    seq(mk(33, 1, 0, CF|CIV, 33, 16'h0861, 0, 0, 0));
    seq(mk(34, 1, 0, CF|CIV, 34, 16'h1122, 0, 0, 0));
    seq(mk(35, 1, 0, CF|CIV, 35, 16'h2233, 0, 0, 0));
    // Stall holds PC and IF/ID; redirect applies even while stalled
    step(0, 0, 0, 0, 0, 0, 0, 0, mk(35, 1, 0, CF|CIV, 35, 16'h2233, 0, 0, 0));
    step(0, 0, 0, 0, 0, 0, 0, 0, mk(35, 1, 0, CF|CIV, 35, 16'h2233, 0, 0, 0));
    step(0, 0, 1, 32'h50, 0, 0, 0, 0, mk(32'h50, 0, 0, CO|CIV, 0, 16'h0000, 0, 0, 0));
    seq(mk(32'h51, 1, 0, CF|CIV, 32'h51, mem_f(32'h50), 0, 0, 0));
    // LDM immediate capture blocks a same-cycle interrupt, which enters next cycle
    step(0, 1, 1, 40, 0, 0, 0, 0, mk(40, 0, 0, CO|CIV, 0, 16'h0000, 0, 0, 0));
    step(0, 1, 0, 0, 0, 0, 1, 1, mk(41, 0, 0, CF|CIV|CI, 0, 16'h0000, 1, 16'hBEEF, 0));
    seq(mk(0, 0, 1, CR, 0, 0, 0, 0, 41));
    step(0, 1, 0, 0, 1, 41, 0, 0, mk(41, 0, 0, CO|CIV|CR, 0, 16'h0000, 0, 0, 41));
    seq(mk(42, 1, 0, CF|CIV, 42, mem_f(41), 0, 0, 0));
    // Interrupt entry at 60, nested request held pending until RTI
    step(0, 1, 1, 60, 0, 0, 0, 0, mk(60, 0, 0, CO, 0, 16'h0000, 0, 0, 0));
    step(0, 1, 0, 0, 0, 0, 1, 0, mk(0, 0, 1, CR, 0, 0, 0, 0, 60));
    seq(mk(1, 1, 0, CF, 1, mem_f(0), 0, 0, 0));
    step(0, 1, 0, 0, 0, 0, 1, 0, mk(2, 1, 0, CF, 2, mem_f(1), 0, 0, 0));
    seq(mk(3, 1, 0, CF, 3, mem_f(2), 0, 0, 0));
    step(0, 1, 0, 0, 1, 60, 0, 0, mk(60, 0, 0, CO|CR, 0, 16'h0000, 0, 0, 60));
    seq(mk(0, 0, 1, CR, 0, 0, 0, 0, 60));
    seq(mk(1, 1, 0, CF|CR, 1, mem_f(0), 0, 0, 60));
    // ret_taken beats branch_taken and clears in_isr so a new request enters
    step(0, 1, 1, 32'h70, 1, 32'h80, 0, 0, mk(32'h80, 0, 0, CO, 0, 16'h0000, 0, 0, 0));
    step(0, 1, 0, 0, 0, 0, 1, 0, mk(0, 0, 1, CR, 0, 0, 0, 0, 32'h80));
    step(0, 1, 0, 0, 1, 32'h80, 0, 0, mk(32'h80, 0, 0, CO, 0, 16'h0000, 0, 0, 0));
    // PC wraps silently from all-ones to zero
    step(0, 1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, mk(32'hFFFF_FFFF, 0, 0, CO, 0, 16'h0000, 0, 0, 0));
    seq(mk(0, 1, 0, CF, 0, mem_f(32'hFFFF_FFFF), 0, 0, 0));
    seq(mk(1, 1, 0, CF, 1, mem_f(0), 0, 0, 0));
    // Reset mid-ISR with a pending request clears everything
    step(0, 1, 0, 0, 0, 0, 1, 0, mk(0, 0, 1, CR, 0, 0, 0, 0, 1));
    step(0, 1, 0, 0, 0, 0, 1, 0, mk(1, 1, 0, CF, 1, mem_f(0), 0, 0, 0));
    step(1, 1, 0, 0, 0, 0, 0, 0, mk(32, 0, 0, CF|CIV|CI|CR, 0, 16'h0000, 0, 0, 0));
    seq(mk(33, 1, 0, CF, 33, 16'h0861, 0, 0, 0));
    seq(mk(34, 1, 0, CF, 34, 16'h1122, 0, 0, 0));
    seq(mk(35, 1, 0, CF, 35, 16'h2233, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
